spram_dmem_ctrl: RTL and testbench

Data-memory controller between the RV32I pipeline's load/store unit and one 16Kx16 single-port SPRAM macro wrapper.
- Accepts one byte, halfword or word request at a time.
- Sequences one or two 16-bit SPRAM accesses per request and generates nibble write masks.
- Returns an assembled, sign- or zero-extended 32-bit load result, or a fault for misaligned or illegal requests.
- Sits directly upstream of the SPRAM wrapper and drives all of its address, data and write-control inputs.

---
 rtl/spram_dmem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spram_dmem_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_dmem_ctrl.sv
// Data-memory controller: turns one RV32I byte/half/word load or store into one or
// two 16-bit accesses on a 16Kx16 single-port SPRAM and returns a 32-bit load result.
module spram_dmem_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic [3:0]        ram_maskwren,
  output logic              ram_wren,
  input  logic [15:0]       ram_dout
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, FIN, RESP} state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [15:0]         lo_q, lo_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_fault_q, resp_fault_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-2:0]   ram_addr_q, ram_addr_d;
  logic [15:0]         ram_din_q, ram_din_d;
  logic [3:0]          ram_mask_q, ram_mask_d;
  logic                ram_wren_q, ram_wren_d;

  logic                req_illegal, req_misal;
  logic                word_q;
  logic [7:0]          ld_byte;
  logic [31:0]         ld_result;

  // Handshake: a request transfers on any edge where req_valid && req_ready; req_ready
  // is high only in IDLE. Responses have no backpressure and last exactly one cycle.
  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_fault   = resp_fault_q;
  assign resp_rdata   = resp_rdata_q;
  assign ram_addr     = ram_addr_q;
  assign ram_din      = ram_din_q;
  assign ram_maskwren = ram_mask_q;
  assign ram_wren     = ram_wren_q;

  assign word_q = (f3_q[1:0] == 2'd2);

  always_comb begin
    req_illegal = req_we ? (req_funct3 > 3'd2)
                         : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
    req_misal   = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    ld_byte = addr_q[0] ? ram_dout[15:8] : ram_dout[7:0];
    case (f3_q[1:0])
      2'd0:    ld_result = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'd1:    ld_result = {{16{ram_dout[15] & ~f3_q[2]}}, ram_dout};
      default: ld_result = {ram_dout, lo_q};
    endcase
  end

  // Write enable and mask default low so every non-write cycle carries a zero mask.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = 32'd0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    ram_mask_d   = 4'b0000;
    ram_wren_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_illegal || req_misal) begin
            state_d = RESP;
          end else begin
            state_d    = ACC0;
            ram_addr_d = (req_funct3[1:0] == 2'd2) ? {req_addr[ADDR_W-1:2], 1'b0}
                                                   : req_addr[ADDR_W-1:1];
            ram_din_d  = (req_funct3[1:0] == 2'd0) ? {2{req_wdata[7:0]}} : req_wdata[15:0];
            ram_wren_d = req_we;
            if (req_we) begin
              ram_mask_d = (req_funct3[1:0] != 2'd0) ? 4'b1111 :
                           (req_addr[0] ? 4'b1100 : 4'b0011);
            end
          end
        end
      end
      ACC0: begin
        if (word_q) begin
          state_d    = ACC1;
          ram_addr_d = {addr_q[ADDR_W-1:2], 1'b1};
          ram_din_d  = wdata_q[31:16];
          ram_wren_d = we_q;
          ram_mask_d = we_q ? 4'b1111 : 4'b0000;
        end else if (we_q) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
        end else begin
          state_d = FIN;
        end
      end
      ACC1: begin
        lo_d = ram_dout;
        if (we_q) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_result;
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_fault_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      lo_q         <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      ram_addr_q   <= '0;
      ram_din_q    <= 16'd0;
      ram_mask_q   <= 4'b0000;
      ram_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_mask_q   <= ram_mask_d;
      ram_wren_q   <= ram_wren_d;
    end
  end

endmodule

// File: tb/tb_spram_dmem_ctrl.sv
// Bench for spram_dmem_ctrl: behavioural SPRAM, byte-level reference memory,
// directed literal checks and a randomized back-to-back request stream.
module tb_spram_dmem_ctrl;
  localparam int ADDR_W = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-2:0] ram_addr;
  logic [15:0]       ram_din;
  logic [3:0]        ram_maskwren;
  logic              ram_wren;
  logic [15:0]       ram_dout;

  spram_dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_dout(ram_dout)
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int unsigned acc_edge;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SPRAM wrapper model: nibble-masked write, registered read
  logic [15:0] sram [0:16383];
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic [3:0] m);
    logic [15:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[4*k +: 4] = din[4*k +: 4];
    return r;
  endfunction
  always @(posedge clk) begin
    if (ram_wren) sram[ram_addr] <= merge(sram[ram_addr], ram_din, ram_maskwren);
    ram_dout <= sram[ram_addr];
  end

  // reference model: byte-addressed memory plus expected response / bus schedule
  logic [7:0]  ref_mem [0:32767];
  logic [32:0] exp_q[$];
  bit          m_busy = 0;
  int unsigned m_due, m_acc_start;
  int          m_acc_n = 0;
  bit          m_st;
  logic [13:0] m_addr [2];
  logic [15:0] m_din  [2];
  logic [3:0]  m_mask [2];

  task automatic model_accept(input logic we, input logic [2:0] f3,
                              input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    int nb, lat, ai;
    bit fault;
    logic [31:0] r;
    ai = int'(a);
    nb = 1 << (int'(f3) % 4);
    fault = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    if (!fault && (ai % nb) != 0) fault = 1;
    r = 32'd0;
    if (fault) begin
      lat = 1;
      m_acc_n = 0;
    end else begin
      m_acc_n = (nb == 4) ? 2 : 1;
      lat = we ? m_acc_n : m_acc_n + 1;
      for (int i = 0; i < m_acc_n; i++) m_addr[i] = 14'((ai / 2) + i);
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[ai + i] = wd[8*i +: 8];
        if (nb == 1) begin
          m_din[0]  = {wd[7:0], wd[7:0]};
          m_mask[0] = (ai % 2 == 1) ? 4'b1100 : 4'b0011;
        end else begin
          m_din[0] = wd[15:0];  m_mask[0] = 4'b1111;
          m_din[1] = wd[31:16]; m_mask[1] = 4'b1111;
        end
      end else begin
        for (int i = 0; i < nb; i++) r[8*i +: 8] = ref_mem[ai + i];
        if (f3 < 3'd4 && nb < 4 && r[8*nb-1])
          for (int i = 8*nb; i < 32; i++) r[i] = 1'b1;
      end
    end
    m_st        = we && !fault;
    m_acc_start = cyc + 1;
    m_due       = cyc + 1 + lat;
    m_busy      = 1;
    exp_q.push_back({fault, r});
  endtask

  // scoreboard / compare process, sampled on the falling edge
  always @(negedge clk) begin
    bit exp_ready, exp_v;
    logic [32:0] e;
    int idx;
    if (reset) begin
      m_busy  = 0;
      m_acc_n = 0;
      exp_q.delete();
    end else begin
      exp_ready = !m_busy || (cyc >= m_due);
      exp_v     = m_busy && (cyc == m_due);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_v));
      if (exp_v) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL exp_q_empty: got response, expected queue empty");
        end else begin
          e = exp_q.pop_front();
          chk("resp_fault", 32'(resp_fault), 32'(e[32]));
          chk("resp_rdata", resp_rdata, e[31:0]);
        end
        m_busy = 0;
      end
      if (m_acc_n > 0 && cyc >= m_acc_start && cyc < m_acc_start + m_acc_n) begin
        idx = int'(cyc - m_acc_start);
        chk("ram_addr", 32'(ram_addr), 32'(m_addr[idx]));
        chk("ram_wren", 32'(ram_wren), 32'(m_st));
        if (m_st) begin
          chk("ram_din", 32'(ram_din), 32'(m_din[idx]));
          chk("ram_mask", 32'(ram_maskwren), 32'(m_mask[idx]));
        end else begin
          chk("ram_mask_read", 32'(ram_maskwren), 32'd0);
        end
      end else begin
        chk("ram_wren_idle", 32'(ram_wren), 32'd0);
        chk("ram_mask_idle", 32'(ram_maskwren), 32'd0);
      end
      if (req_valid && exp_ready) model_accept(req_we, req_funct3, req_addr, req_wdata);
    end
  end

  // driver tasks
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd);
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL accept_timeout: req_ready stayed 0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    acc_edge = cyc;
  endtask

  task automatic expect_resp(input string nm, input logic [31:0] rd, input logic f,
                             input int lat);
    int seen;
    seen = -1;
    for (int i = 0; i < 12 && seen < 0; i++) begin
      @(negedge clk);
      if (resp_valid) seen = int'(cyc - acc_edge);
    end
    if (seen < 0) begin
      n_checks++; n_err++;
      $display("FAIL %s: resp_valid absent for 12 cycles, expected latency %0d", nm, lat);
    end else begin
      chk({nm, "_lat"}, 32'(seen), 32'(lat));
      chk({nm, "_rdata"}, resp_rdata, rd);
      chk({nm, "_fault"}, 32'(resp_fault), 32'(f));
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_bus(input string nm, input logic [13:0] a, input logic [15:0] d,
                         input logic [3:0] m);
    chk({nm, "_addr"}, 32'(ram_addr), 32'(a));
    chk({nm, "_din"}, 32'(ram_din), 32'(d));
    chk({nm, "_mask"}, 32'(ram_maskwren), 32'(m));
    chk({nm, "_wren"}, 32'(ram_wren), 32'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_fault"}, 32'(resp_fault), 32'd0);
    chk({nm, "_rdata"}, resp_rdata, 32'd0);
    chk({nm, "_wren"}, 32'(ram_wren), 32'd0);
    chk({nm, "_mask"}, 32'(ram_maskwren), 32'd0);
    chk({nm, "_addr"}, 32'(ram_addr), 32'd0);
    chk({nm, "_din"}, 32'(ram_din), 32'd0);
  endtask

  function automatic logic [2:0] pick_f3(input logic we);
    logic [2:0] lds [5];
    lds[0] = 3'd0; lds[1] = 3'd1; lds[2] = 3'd2; lds[3] = 3'd4; lds[4] = 3'd5;
    if ($urandom_range(0, 9) == 0) return 3'($urandom_range(0, 7));
    if (we) return 3'($urandom_range(0, 2));
    return lds[$urandom_range(0, 4)];
  endfunction

  initial begin
    logic              we;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] a;
    int                nb;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = 32'd0;
    for (int i = 0; i < 16384; i++) begin
      sram[i]          = 16'($urandom);
      ref_mem[2*i]     = sram[i][7:0];
      ref_mem[2*i + 1] = sram[i][15:8];
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;
    @(posedge clk); #1;

    // word store then load, with literal bus contents
    issue(1'b1, 3'd2, 15'h0004, 32'h12345678); req_valid = 1'b0;
    chk_bus("sw_acc0", 14'h0002, 16'h5678, 4'b1111);
    @(posedge clk); #1;
    chk_bus("sw_acc1", 14'h0003, 16'h1234, 4'b1111);
    expect_resp("sw", 32'd0, 1'b0, 2);
    issue(1'b0, 3'd2, 15'h0004, 32'd0); req_valid = 1'b0;
    expect_resp("lw", 32'h12345678, 1'b0, 3);

    // byte store into upper half, loads of several widths
    issue(1'b1, 3'd0, 15'h0005, 32'h000000AB); req_valid = 1'b0;
    chk_bus("sb", 14'h0002, 16'hABAB, 4'b1100);
    expect_resp("sb", 32'd0, 1'b0, 1);
    issue(1'b0, 3'd2, 15'h0004, 32'd0); req_valid = 1'b0;
    expect_resp("lw_after_sb", 32'h1234AB78, 1'b0, 3);
    issue(1'b0, 3'd0, 15'h0005, 32'd0); req_valid = 1'b0;
    expect_resp("lb", 32'hFFFFFFAB, 1'b0, 2);
    issue(1'b0, 3'd4, 15'h0005, 32'd0); req_valid = 1'b0;
    expect_resp("lbu", 32'h000000AB, 1'b0, 2);

    // halfword
    issue(1'b1, 3'd1, 15'h0006, 32'h00008001); req_valid = 1'b0;
    chk_bus("sh", 14'h0003, 16'h8001, 4'b1111);
    expect_resp("sh", 32'd0, 1'b0, 1);
    issue(1'b0, 3'd1, 15'h0006, 32'd0); req_valid = 1'b0;
    expect_resp("lh", 32'hFFFF8001, 1'b0, 2);
    issue(1'b0, 3'd5, 15'h0006, 32'd0); req_valid = 1'b0;
    expect_resp("lhu", 32'h00008001, 1'b0, 2);

    // faults
    issue(1'b0, 3'd1, 15'h0003, 32'd0); req_valid = 1'b0;
    expect_resp("f_lh_mis", 32'd0, 1'b1, 1);
    issue(1'b1, 3'd2, 15'h0002, 32'hDEADBEEF); req_valid = 1'b0;
    expect_resp("f_sw_mis", 32'd0, 1'b1, 1);
    issue(1'b0, 3'd3, 15'h0000, 32'd0); req_valid = 1'b0;
    expect_resp("f_ld3", 32'd0, 1'b1, 1);
    issue(1'b1, 3'd5, 15'h0000, 32'd0); req_valid = 1'b0;
    expect_resp("f_st5", 32'd0, 1'b1, 1);

    // top word of memory
    issue(1'b1, 3'd2, 15'h7FFC, 32'hA5C3_0F96); req_valid = 1'b0;
    chk_bus("top_acc0", 14'h3FFE, 16'h0F96, 4'b1111);
    @(posedge clk); #1;
    chk_bus("top_acc1", 14'h3FFF, 16'hA5C3, 4'b1111);
    expect_resp("top_sw", 32'd0, 1'b0, 2);
    issue(1'b0, 3'd2, 15'h7FFC, 32'd0); req_valid = 1'b0;
    expect_resp("top_lw", 32'hA5C30F96, 1'b0, 3);

    // back-to-back stream with req_valid held high
    issue(1'b1, 3'd0, 15'h0020, 32'h00000011);
    issue(1'b0, 3'd2, 15'h0020, 32'd0);
    issue(1'b1, 3'd0, 15'h0023, 32'h00000099);
    issue(1'b0, 3'd2, 15'h0020, 32'd0);
    issue(1'b1, 3'd2, 15'h7FFC, 32'h0BADF00D);
    issue(1'b0, 3'd2, 15'h7FFC, 32'd0);
    req_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    // reset during the second access of a word store
    issue(1'b1, 3'd2, 15'h0010, 32'h11112222); req_valid = 1'b0;
    expect_resp("pre_sw", 32'd0, 1'b0, 2);
    issue(1'b1, 3'd2, 15'h0010, 32'h33334444); req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    ref_mem[16'h0012] = 8'h11;
    ref_mem[16'h0013] = 8'h11;
    repeat (2) @(posedge clk); #1;
    issue(1'b0, 3'd2, 15'h0010, 32'd0); req_valid = 1'b0;
    expect_resp("post_rst_lw", 32'h11114444, 1'b0, 3);

    // randomized stream
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = pick_f3(we);
      if ($urandom_range(0, 3) == 0) a = 15'(15'h7FC0 + $urandom_range(0, 63));
      else a = 15'($urandom_range(0, 63));
      nb = 1 << (int'(f3) % 4);
      if ($urandom_range(0, 4) != 0) a = 15'(int'(a) - (int'(a) % nb));
      issue(we, f3, a, $urandom);
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 1'b0;
        req_we = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr = 15'($urandom);
        req_wdata = $urandom;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
